// File: rtl/bilinear_interp_packer_if.sv
// Pixel/fraction input bus and packed-word output bus of the bilinear interpolator/packer.
// The master drives pixels and flush; the slave (the packer) drives packed words.
interface bilinear_interp_packer_if #(
    parameter int FRAC_BITS = 2
);
    logic [64:0]            pix_in;
    logic [2*FRAC_BITS-1:0] frac_in;
    logic                   pix_in_valid;
    logic                   flush;
    logic [63:0]            out_word;
    logic [3:0]             out_lane_mask;
    logic                   out_gray;
    logic                   out_valid;

    modport master (
        output pix_in, frac_in, pix_in_valid, flush,
        input  out_word, out_lane_mask, out_gray, out_valid
    );

    modport slave (
        input  pix_in, frac_in, pix_in_valid, flush,
        output out_word, out_lane_mask, out_gray, out_valid
    );
endinterface

// File: rtl/bilinear_interp_packer.sv
// Bilinear interpolation of a 2x2 neighbourhood (gray16 or RGB565), then packing of
// consecutive same-format pixels into 4-lane 64-bit words with flush support.
module bilinear_interp_packer #(
    parameter int FRAC_BITS = 2
) (
    input  logic                     buf_read_clk,
    input  logic                     reset,
    bilinear_interp_packer_if.slave  bus
);
    localparam int S  = 2**FRAC_BITS;
    localparam int WW = 2*FRAC_BITS + 1;
    localparam int SW = 16 + 2*FRAC_BITS + 2;
    localparam int SH = 2*FRAC_BITS;

    logic [FRAC_BITS-1:0]  w_fx, w_fy;
    logic [WW-1:0]         w_sx, w_sy;
    logic [3:0][WW-1:0]    w_wt;

    logic [3:0][WW-1:0]    r_s1_wt;
    logic [3:0][15:0]      r_s1_pix;
    logic                  r_s1_gray;
    logic                  r_s1_valid;

    logic [2:0][3:0][15:0] w_ch;
    logic [2:0][3:0][SW-1:0] r_s2_prod;
    logic                  r_s2_gray;
    logic                  r_s2_valid;

    logic [2:0][SW-1:0]    w_sum;
    logic [15:0]           w_s3_pix;

    logic [1:0]            r_count;
    logic [3:0][15:0]      r_lane;
    logic                  r_gray;
    logic                  r_pend;
    logic [63:0]           r_out_word;
    logic [3:0]            r_out_mask;
    logic                  r_out_gray;
    logic                  r_out_valid;

    logic                  w_flush_eff;
    logic [2:0]            w_cnt_inc;
    logic [3:0][15:0]      w_app;
    logic [1:0]            w_count_n;
    logic [3:0][15:0]      w_lane_n;
    logic                  w_gray_n;
    logic                  w_pend_n;
    logic                  w_emit;
    logic [63:0]           w_emit_word;
    logic [3:0]            w_emit_mask;
    logic                  w_emit_gray;

    function automatic logic [3:0] mask_of(input logic [2:0] c);
        mask_of = 4'((5'd1 << c) - 5'd1);
    endfunction

    assign w_fx    = bus.frac_in[FRAC_BITS-1:0];
    assign w_fy    = bus.frac_in[2*FRAC_BITS-1:FRAC_BITS];
    assign w_sx    = WW'(S) - WW'(w_fx);
    assign w_sy    = WW'(S) - WW'(w_fy);
    assign w_wt[0] = w_sx * w_sy;
    assign w_wt[1] = WW'(w_fx) * w_sy;
    assign w_wt[2] = w_sx * WW'(w_fy);
    assign w_wt[3] = WW'(w_fx) * WW'(w_fy);

    // Gray uses channel 0 as the full 16-bit sample; RGB565 splits into R/G/B channels.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_s1_gray) begin
                w_ch[0][i] = r_s1_pix[i];
                w_ch[1][i] = '0;
                w_ch[2][i] = '0;
            end else begin
                w_ch[0][i] = {11'd0, r_s1_pix[i][15:11]};
                w_ch[1][i] = {10'd0, r_s1_pix[i][10:5]};
                w_ch[2][i] = {11'd0, r_s1_pix[i][4:0]};
            end
        end
    end

    always_ff @(posedge buf_read_clk) begin
        r_s1_wt   <= w_wt;
        r_s1_pix  <= bus.pix_in[63:0];
        r_s1_gray <= bus.pix_in[64];
        r_s2_gray <= r_s1_gray;
        for (int unsigned c = 0; c < 3; c++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                r_s2_prod[c][i] <= SW'(w_ch[c][i]) * SW'(r_s1_wt[i]);
            end
        end
    end

    always_ff @(posedge buf_read_clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= bus.pix_in_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    // Sum/round/shift is the third stage; its register is the packer's output register.
    always_comb begin
        for (int unsigned c = 0; c < 3; c++) begin
            w_sum[c] = SW'(S*S/2);
            for (int unsigned i = 0; i < 4; i++) begin
                w_sum[c] = w_sum[c] + r_s2_prod[c][i];
            end
        end
        if (r_s2_gray) begin
            w_s3_pix = 16'(w_sum[0] >> SH);
        end else begin
            w_s3_pix = {5'(w_sum[0] >> SH), 6'(w_sum[1] >> SH), 5'(w_sum[2] >> SH)};
        end
    end

    // A pending flush behaves exactly like a flush request on the following cycle.
    always_comb begin
        w_flush_eff        = bus.flush | r_pend;
        w_cnt_inc          = {1'b0, r_count} + 3'd1;
        w_app              = r_lane;
        w_app[r_count]     = w_s3_pix;
        w_count_n          = r_count;
        w_lane_n           = r_lane;
        w_gray_n           = r_gray;
        w_pend_n           = 1'b0;
        w_emit             = 1'b0;
        w_emit_word        = '0;
        w_emit_mask        = '0;
        w_emit_gray        = 1'b0;
        if (r_s2_valid) begin
            if (r_count == 2'd0 || r_s2_gray == r_gray) begin
                if (w_cnt_inc == 3'd4 || w_flush_eff) begin
                    w_emit      = 1'b1;
                    w_emit_word = w_app;
                    w_emit_mask = mask_of(w_cnt_inc);
                    w_emit_gray = r_s2_gray;
                    w_count_n   = 2'd0;
                    w_lane_n    = '0;
                end else begin
                    w_lane_n    = w_app;
                    w_count_n   = w_cnt_inc[1:0];
                    w_gray_n    = r_s2_gray;
                end
            end else begin
                w_emit      = 1'b1;
                w_emit_word = r_lane;
                w_emit_mask = mask_of({1'b0, r_count});
                w_emit_gray = r_gray;
                w_lane_n    = '0;
                w_lane_n[0] = w_s3_pix;
                w_count_n   = 2'd1;
                w_gray_n    = r_s2_gray;
                w_pend_n    = w_flush_eff;
            end
        end else if (w_flush_eff && r_count != 2'd0) begin
            w_emit      = 1'b1;
            w_emit_word = r_lane;
            w_emit_mask = mask_of({1'b0, r_count});
            w_emit_gray = r_gray;
            w_count_n   = 2'd0;
            w_lane_n    = '0;
        end
    end

    always_ff @(posedge buf_read_clk) begin
        if (reset) begin
            r_count     <= 2'd0;
            r_lane      <= '0;
            r_gray      <= 1'b0;
            r_pend      <= 1'b0;
            r_out_word  <= '0;
            r_out_mask  <= '0;
            r_out_gray  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_count     <= w_count_n;
            r_lane      <= w_lane_n;
            r_gray      <= w_gray_n;
            r_pend      <= w_pend_n;
            r_out_word  <= w_emit_word;
            r_out_mask  <= w_emit_mask;
            r_out_gray  <= w_emit_gray;
            r_out_valid <= w_emit;
        end
    end

    assign bus.out_word      = r_out_word;
    assign bus.out_lane_mask = r_out_mask;
    assign bus.out_gray      = r_out_gray;
    assign bus.out_valid     = r_out_valid;
endmodule

// File: tb/tb_bilinear_interp_packer.sv
// Cycle-exact bench: arithmetic interpolation model plus a queue-based packing model,
// directed cases from the known examples followed by randomized traffic.
module tb_bilinear_interp_packer;
    localparam int F  = 2;
    localparam int S  = 2**F;
    localparam int SH = 2*F;
    localparam int H  = S*S/2;

    logic buf_read_clk;
    logic reset;

    bilinear_interp_packer_if #(.FRAC_BITS(F)) bus ();

    bilinear_interp_packer #(.FRAC_BITS(F)) dut (
        .buf_read_clk (buf_read_clk),
        .reset        (reset),
        .bus          (bus.slave)
    );

    initial buf_read_clk = 1'b0;
    always #5 buf_read_clk = ~buf_read_clk;

    typedef struct {
        int          due;
        logic [15:0] pix;
        logic        g;
    } item_t;

    item_t       pq[$];
    logic [15:0] held[$];
    logic        hgray;
    logic        pend;
    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [63:0] last_word;
    logic [3:0]  last_mask;
    logic        last_gray;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] interp(input logic [64:0] p, input int fx, input int fy);
        int unsigned w[4];
        int unsigned acc[3];
        int unsigned px;
        w[0] = (S-fx)*(S-fy);
        w[1] = fx*(S-fy);
        w[2] = (S-fx)*fy;
        w[3] = fx*fy;
        acc = '{default: 0};
        for (int i = 0; i < 4; i++) begin
            px = 32'(p[16*i +: 16]);
            if (p[64]) begin
                acc[0] += w[i] * px;
            end else begin
                acc[0] += w[i] * ((px >> 11) & 32'd31);
                acc[1] += w[i] * ((px >> 5) & 32'd63);
                acc[2] += w[i] * (px & 32'd31);
            end
        end
        if (p[64]) return 16'((acc[0] + H) >> SH);
        return {5'((acc[0] + H) >> SH), 6'((acc[1] + H) >> SH), 5'((acc[2] + H) >> SH)};
    endfunction

    task automatic take(output logic [63:0] ew, output logic [3:0] em);
        ew = '0;
        for (int i = 0; i < held.size(); i++) ew[16*i +: 16] = held[i];
        em = 4'((1 << held.size()) - 1);
        held.delete();
    endtask

    task automatic model_edge(input logic fl, output logic ev, output logic [63:0] ew,
                              output logic [3:0] em, output logic eg);
        logic fe, av, ag;
        logic [15:0] ap;
        ev = 1'b0; ew = '0; em = '0; eg = 1'b0;
        fe = fl | pend;
        pend = 1'b0;
        av = 1'b0; ap = '0; ag = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            av = 1'b1; ap = pq[0].pix; ag = pq[0].g;
            pq.delete(0);
        end
        if (av) begin
            if (held.size() == 0 || ag == hgray) begin
                held.push_back(ap);
                hgray = ag;
                if (held.size() == 4 || fe) begin
                    ev = 1'b1; eg = hgray; take(ew, em);
                end
            end else begin
                ev = 1'b1; eg = hgray; take(ew, em);
                held.push_back(ap);
                hgray = ag;
                pend = fe;
            end
        end else if (fe && held.size() > 0) begin
            ev = 1'b1; eg = hgray; take(ew, em);
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [64:0] p,
                        input logic [3:0] fr, input logic fl);
        logic ev, eg;
        logic [63:0] ew;
        logic [3:0] em;
        reset            = rst;
        bus.pix_in_valid = v;
        bus.pix_in       = p;
        bus.frac_in      = fr;
        bus.flush        = fl;
        ev = 1'b0; ew = '0; em = '0; eg = 1'b0;
        if (rst) begin
            pq.delete();
            held.delete();
            pend = 1'b0;
        end else begin
            model_edge(fl, ev, ew, em, eg);
            if (v) pq.push_back('{cyc + 2, interp(p, int'(fr[1:0]), int'(fr[3:2])), p[64]});
        end
        @(posedge buf_read_clk);
        cyc++;
        @(negedge buf_read_clk);
        check_eq("out_valid", 64'(bus.out_valid), 64'(ev));
        if (rst) begin
            check_eq("reset_word", bus.out_word, 64'd0);
            check_eq("reset_mask", 64'(bus.out_lane_mask), 64'd0);
            check_eq("reset_gray", 64'(bus.out_gray), 64'd0);
        end
        if (ev) begin
            check_eq("out_word", bus.out_word, ew);
            check_eq("out_lane_mask", 64'(bus.out_lane_mask), 64'(em));
            check_eq("out_gray", 64'(bus.out_gray), 64'(eg));
        end
        if (bus.out_valid) begin
            last_word = bus.out_word;
            last_mask = bus.out_lane_mask;
            last_gray = bus.out_gray;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic flush_step();
        step(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic pix(input logic g, input logic [63:0] d, input logic [3:0] fr);
        step(1'b0, 1'b1, {g, d}, fr, 1'b0);
    endtask

    initial begin
        logic g, v, fl, r;
        logic [64:0] p;
        logic [3:0] fr;
        n_checks = 0; n_errors = 0; cyc = 0; pend = 1'b0; hgray = 1'b0;
        last_word = '0; last_mask = '0; last_gray = 1'b0;
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);

        // gray, all 0x1000, fx=1 fy=2, four identical inputs
        for (int i = 0; i < 4; i++) pix(1'b1, {4{16'h1000}}, 4'b1001);
        idle(); idle();
        check_eq("full_word", last_word, 64'h1000_1000_1000_1000);
        check_eq("full_mask", 64'(last_mask), 64'hF);
        check_eq("full_gray", 64'(last_gray), 64'd1);

        // gray, p01=0x0100, fx=2 fy=0, flushed alone
        pix(1'b1, {16'h0, 16'h0, 16'h0100, 16'h0}, 4'b0010);
        idle(); idle(); flush_step();
        check_eq("gray_lane0", last_word, 64'h0080);
        check_eq("gray_mask", 64'(last_mask), 64'h1);

        // RGB565, p00=0xF800, fx=1 fy=1
        pix(1'b0, {16'h0, 16'h0, 16'h0, 16'hF800}, 4'b0101);
        idle(); idle(); flush_step();
        check_eq("rgb_lane0", last_word, 64'h8800);
        check_eq("rgb_gray", 64'(last_gray), 64'd0);

        // two RGB then one gray pixel
        pix(1'b0, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        pix(1'b0, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        idle(); idle();
        check_eq("switch_mask", 64'(last_mask), 64'h3);
        check_eq("switch_gray", 64'(last_gray), 64'd0);
        flush_step();
        check_eq("switch_tail_mask", 64'(last_mask), 64'h1);
        check_eq("switch_tail_gray", 64'(last_gray), 64'd1);

        // flush on the cycle a differing-gray pixel reaches the packer
        pix(1'b0, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        idle(); flush_step();
        check_eq("pend_old_mask", 64'(last_mask), 64'h1);
        check_eq("pend_old_gray", 64'(last_gray), 64'd0);
        idle();
        check_eq("pend_new_mask", 64'(last_mask), 64'h1);
        check_eq("pend_new_gray", 64'(last_gray), 64'd1);

        // pending flush absorbed by a following same-gray pixel
        pix(1'b0, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        step(1'b0, 1'b0, '0, '0, 1'b1);
        idle(); idle();
        check_eq("pend_append_mask", 64'(last_mask), 64'h3);

        // reset with a partial word held and two pixels in flight
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        idle(); idle();
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        pix(1'b1, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) idle();
        flush_step();
        pix(1'b0, {$urandom(), $urandom()}, 4'($urandom_range(15)));
        idle(); idle(); flush_step();

        g = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(99) < 15) g = ~g;
            v  = ($urandom_range(99) < 70);
            p  = {g, $urandom(), $urandom()};
            fr = 4'($urandom_range(15));
            fl = ($urandom_range(99) < 10);
            r  = ($urandom_range(199) < 3);
            step(r, v, p, fr, fl);
        end
        idle(); idle(); idle(); flush_step(); idle(); idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bilinear_interp_packer.md
BILINEAR_INTERP_PACKER -- requirements
Module: bilinear_interp_packer

Interface
REQ-001 Parameter FRAC_BITS, default 2: fractional bits per coordinate axis; weight scale S = 2^FRAC_BITS.
REQ-002 buf_read_clk  input  1  clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 pix_in  input  65  [15:0]=p00 (top-left), [31:16]=p01 (top-right), [47:32]=p10 (bottom-left), [63:48]=p11 (bottom-right), [64]=gray flag.
REQ-005 frac_in  input  2*FRAC_BITS  [FRAC_BITS-1:0]=fx (column fraction), upper half=fy (row fraction).
REQ-006 pix_in_valid  input  1  qualifies pix_in and frac_in.
REQ-007 flush  input  1  single-cycle request to emit any partially packed word.
REQ-008 out_word  output  64  four 16-bit pixel lanes, lane k at [16k+15:16k].
REQ-009 out_lane_mask  output  4  bit k set = lane k holds a valid pixel.
REQ-010 out_gray  output  1  gray flag shared by all valid lanes of out_word.
REQ-011 out_valid  output  1  qualifies out_word, out_lane_mask and out_gray for exactly one cycle.

Function
REQ-012 No back-pressure; the block SHALL accept one input per cycle whenever pix_in_valid=1.
REQ-013 Weights: w00=(S-fx)(S-fy), w01=fx(S-fy), w10=(S-fx)fy, w11=fx*fy; sum always S^2.
REQ-014 Gray=1: pixel is one unsigned 16-bit channel; result = (w00*p00 + w01*p01 + w10*p10 + w11*p11 + S^2/2) >> (2*FRAC_BITS).
REQ-015 Gray=0: pixel is RGB565 (R[15:11], G[10:5], B[4:0]); the REQ-014 formula SHALL be applied per channel independently and the channels repacked.
REQ-016 Intermediate sums SHALL be full width (16 + 2*FRAC_BITS + 2 bits minimum); result never exceeds the max input channel, so no saturation logic is needed.
REQ-017 Interpolation pipeline: 3 register stages (weights; four products; sum/round/shift); interpolated pixel, its gray flag and valid emerge 3 cycles after input acceptance.
REQ-018 Packer state: count 0..3, lane registers, packed gray flag; it consumes the stage-3 pixel.
REQ-019 Pixel arrives, count=0 or gray matches: store in lane count; if count becomes 4, emit word with mask 1111 that cycle and reset count to 0.
REQ-020 Pixel arrives, count>0 and gray differs: emit held partial word (its mask, its gray) that cycle; new pixel stored in lane 0, count=1.
REQ-021 flush with no arriving pixel: if count>0 emit partial word and clear count; if count=0 no output.
REQ-022 flush with arriving pixel of matching gray: append pixel, then emit the resulting word (partial or full) that cycle; count=0.
REQ-023 flush with arriving pixel of differing gray: emit old partial this cycle per REQ-020; the new single pixel SHALL be emitted (mask 0001) on the next cycle via an internal pending-flush flag, unless another pixel arrives then, in which case it is appended first and the resulting word emitted.
REQ-024 Lanes not set in out_lane_mask SHALL read as zero.
REQ-025 flush is not pipelined with data; bench/upstream SHALL assert it at least 3 cycles after the last pixel to include that pixel.

Reset
REQ-026 On reset: out_valid=0, out_word=0, out_lane_mask=0, out_gray=0, count=0, pending-flush=0, all pipeline valids=0.
REQ-027 Reset mid-operation SHALL discard in-flight pipeline pixels and any partial word without emitting them; first output after reset derives only from post-reset inputs.

Verification
REQ-028 Gray, all four pixels 0x1000, fx=1 fy=2, then 3 more identical -> one word 0x1000_1000_1000_1000, mask 1111, gray=1, out_valid on cycle 3 after fourth input.
REQ-029 Gray, p01=0x0100 others 0, fx=2 fy=0, then flush -> lane0=0x0080, mask 0001.
REQ-030 RGB565, p00=0xF800 others 0, fx=1 fy=1, then flush -> lane0=0x8800 (R=17, G=0, B=0).
REQ-031 Two gray=0 pixels then one gray=1 pixel consecutively, then flush -> word mask 0011 gray=0 on third pixel's exit cycle; next word mask 0001 gray=1.
REQ-032 Flush coinciding with differing-gray pixel -> old partial emitted that cycle, mask 0001 word on the following cycle.
REQ-033 Two pixels in flight, reset asserted one cycle -> no out_valid until new inputs traverse 3 stages.
